// File: rtl/ldpc_pkg.sv
// Shared LLR definitions for the decoder datapath: sign-magnitude word layout
// used by the VNU output, the shuffle network and the CNU.
package ldpc_pkg;
   localparam int LLR_SM_W    = 6;
   localparam int LLR_MAG_MAX = 31;

   typedef logic [LLR_SM_W-1:0] llr_sm_t;
endpackage

// File: rtl/compl2sm_sat.sv
// Combinational two's-complement to sign-magnitude conversion with magnitude
// saturation; shared by the VNU output pipeline and the CNU output.
module compl2sm_sat
   import ldpc_pkg::*;
#(
   parameter int IN_W  = 8,
   parameter int OUT_W = LLR_SM_W
) (
   input  logic [IN_W-1:0]  data_i,
   output logic [OUT_W-1:0] sm_o,
   output logic             sat_o
);

   localparam logic [IN_W:0] MAXM = (IN_W+1)'((1 << (OUT_W-1)) - 1);

   logic             sign;
   logic [IN_W:0]    ext;
   logic [IN_W:0]    abs_v;
   logic [OUT_W-2:0] mag;

   always_comb begin
      sign  = data_i[IN_W-1];
      ext   = {sign, data_i};
      // One extra bit so that negating the most negative input cannot overflow.
      abs_v = sign ? (-ext) : ext;
      sat_o = (abs_v > MAXM);
      mag   = sat_o ? '1 : abs_v[OUT_W-2:0];
      // A zero magnitude always carries a positive sign.
      sm_o  = {sign & (|mag), mag};
   end

endmodule

// File: rtl/compl2sm_sat_pipe.sv
// Two-stage valid/ready pipeline converting two's-complement LLRs to saturated
// sign-magnitude, with a per-frame count of saturated words.
module compl2sm_sat_pipe
   import ldpc_pkg::*;
#(
   parameter int IN_W      = 8,
   parameter int OUT_W     = LLR_SM_W,
   parameter int SAT_CNT_W = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [IN_W-1:0]      i_data,
   input  logic                 i_last,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [OUT_W-1:0]     o_data,
   output logic                 o_sat,
   output logic                 o_last,
   output logic [SAT_CNT_W-1:0] o_sat_cnt
);

   if (IN_W < OUT_W) begin : g_bad_width
      $error("compl2sm_sat_pipe: IN_W must be >= OUT_W");
   end

   logic                 en;
   logic                 s1_valid_q;
   logic                 s1_last_q;
   logic [IN_W-1:0]      s1_data_q;
   logic                 o_valid_q;
   logic [OUT_W-1:0]     o_data_q;
   logic                 o_sat_q;
   logic                 o_last_q;
   logic [SAT_CNT_W-1:0] cnt_q;
   logic [SAT_CNT_W-1:0] cnt_d;
   logic [SAT_CNT_W-1:0] cnt_base;
   logic [OUT_W-1:0]     sm;
   logic                 sat;

   compl2sm_sat #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_conv (
      .data_i (s1_data_q),
      .sm_o   (sm),
      .sat_o  (sat)
   );

   always_comb begin
      en       = ~o_valid_q | i_ready;
      // A frame's count is dropped as its last word leaves, so the word loaded
      // on the same edge starts the next frame from zero.
      cnt_base = (o_valid_q & i_ready & o_last_q) ? '0 : cnt_q;
      cnt_d    = cnt_q;
      if (en) begin
         cnt_d = cnt_base;
         if (s1_valid_q & sat & ~(&cnt_base)) begin
            cnt_d = cnt_base + SAT_CNT_W'(1);
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1_valid_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_data_q  <= '0;
         o_valid_q  <= 1'b0;
         o_data_q   <= '0;
         o_sat_q    <= 1'b0;
         o_last_q   <= 1'b0;
         cnt_q      <= '0;
      end else begin
         if (en) begin
            s1_valid_q <= i_valid;
            s1_last_q  <= i_last;
            s1_data_q  <= i_data;
            o_valid_q  <= s1_valid_q;
            o_data_q   <= sm;
            o_sat_q    <= sat;
            o_last_q   <= s1_last_q;
         end
         cnt_q <= cnt_d;
      end
   end

   assign o_ready   = en;
   assign o_valid   = o_valid_q;
   assign o_data    = o_data_q;
   assign o_sat     = o_sat_q;
   assign o_last    = o_last_q;
   assign o_sat_cnt = cnt_q;

endmodule
